text_mem_scheduler: RTL and testbench

Access controller for the character and colour text-page RAMs (80×60 = 4800 cells, 13-bit linear address, 8-bit data each). It gives the RAMs to the scanout path while the display is active. During blanking it shares them between three requesters, in priority order: a whole-screen clear engine, a single-cell write port and a single-cell read port. It drives the address select of the existing address mux and the write enables of both RAMs.

---
 rtl/text_mem_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_text_mem_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_mem_scheduler.sv
// text_mem_scheduler: arbitrates the character and colour text-page RAMs.
// Scanout owns the RAMs while disp is high; during blanking a whole-screen
// clear engine, a single-cell write port and a single-cell read port share
// them in that priority order.
module text_mem_scheduler #(
    parameter int CELLS  = 4800,
    parameter int ADDR_W = 13
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              disp,
    input  logic              clr_req,
    input  logic [7:0]        clr_char,
    input  logic [7:0]        clr_colour,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_char,
    input  logic [7:0]        wr_colour,
    input  logic [1:0]        wr_mask,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data_valid,
    output logic [7:0]        rd_char,
    output logic [7:0]        rd_colour,
    output logic              mem_own,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_char_d,
    output logic [7:0]        mem_col_d,
    output logic              mem_char_we,
    output logic              mem_col_we,
    input  logic [7:0]        mem_char_q,
    input  logic [7:0]        mem_col_q,
    output logic              busy,
    output logic              clr_done
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // One extra bit so the comparison stays correct even if CELLS == 2**ADDR_W.
    localparam logic [ADDR_W:0]   CELLS_W  = (ADDR_W + 1)'(CELLS);
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(CELLS - 1);

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] clr_cnt_r;
    logic [ADDR_W-1:0] clr_cnt_s;
    logic [7:0]        fill_char_r;
    logic [7:0]        fill_col_r;
    logic              clr_done_r;
    logic              clr_done_s;
    logic              rd_pend_r;
    logic              rd_oob_r;
    logic              rd_data_valid_r;
    logic [7:0]        rd_char_r;
    logic [7:0]        rd_colour_r;
    logic              wr_fire_s;
    logic              rd_fire_s;
    logic              clr_start_s;

    // True when a cell address lies inside the text page.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < CELLS_W);
    endfunction

    assign mem_own       = ~disp;
    assign busy          = (state_r == ST_CLEAR);
    assign clr_done      = clr_done_r;
    assign rd_data_valid = rd_data_valid_r;
    assign rd_char       = rd_char_r;
    assign rd_colour     = rd_colour_r;

    // Port handshakes and the RAM address/data/enable mux for this cycle.
    always_comb begin
        wr_ready    = ~disp & (state_r == ST_IDLE) & ~clr_req;
        rd_ready    = ~disp & (state_r == ST_IDLE) & ~clr_req & ~wr_valid;
        wr_fire_s   = wr_ready & wr_valid;
        rd_fire_s   = rd_ready & rd_valid;
        mem_addr    = {ADDR_W{1'b0}};
        mem_char_d  = 8'h00;
        mem_col_d   = 8'h00;
        mem_char_we = 1'b0;
        mem_col_we  = 1'b0;
        if (disp) begin
            // Scanout owns the RAMs; keep every enable low.
            mem_addr = {ADDR_W{1'b0}};
        end else if (state_r == ST_CLEAR) begin
            mem_addr    = clr_cnt_r;
            mem_char_d  = fill_char_r;
            mem_col_d   = fill_col_r;
            mem_char_we = 1'b1;
            mem_col_we  = 1'b1;
        end else if (wr_fire_s) begin
            mem_addr    = wr_addr;
            mem_char_d  = wr_char;
            mem_col_d   = wr_colour;
            // Out-of-range writes are accepted but never reach the RAMs.
            mem_char_we = wr_mask[0] & addr_in_range(wr_addr);
            mem_col_we  = wr_mask[1] & addr_in_range(wr_addr);
        end else if (rd_fire_s) begin
            mem_addr = rd_addr;
        end else begin
            mem_addr = {ADDR_W{1'b0}};
        end
    end

    // Clear engine next-state logic: start on request, step only in blanking.
    always_comb begin
        state_s     = state_r;
        clr_cnt_s   = clr_cnt_r;
        clr_done_s  = 1'b0;
        clr_start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clr_req) begin
                    clr_start_s = 1'b1;
                    clr_cnt_s   = {ADDR_W{1'b0}};
                    state_s     = ST_CLEAR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (!disp) begin
                    clr_cnt_s = clr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (clr_cnt_r == LAST_CNT) begin
                        state_s    = ST_IDLE;
                        clr_done_s = 1'b1;
                    end else begin
                        state_s = ST_CLEAR;
                    end
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Clear engine state, counter, fill values and completion pulse.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r     <= ST_IDLE;
            clr_cnt_r   <= {ADDR_W{1'b0}};
            fill_char_r <= 8'h00;
            fill_col_r  <= 8'h00;
            clr_done_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            clr_cnt_r  <= clr_cnt_s;
            clr_done_r <= clr_done_s;
            if (clr_start_s) begin
                fill_char_r <= clr_char;
                fill_col_r  <= clr_colour;
            end else begin
                fill_char_r <= fill_char_r;
                fill_col_r  <= fill_col_r;
            end
        end
    end

    // Read pipeline: RAM data appears one cycle after accept and is captured
    // then, whatever disp is doing, so rd_data_valid lands two cycles later.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_pend_r       <= 1'b0;
            rd_oob_r        <= 1'b0;
            rd_data_valid_r <= 1'b0;
            rd_char_r       <= 8'h00;
            rd_colour_r     <= 8'h00;
        end else begin
            rd_pend_r <= rd_fire_s;
            rd_oob_r  <= ~addr_in_range(rd_addr);
            if (rd_pend_r) begin
                rd_data_valid_r <= 1'b1;
                rd_char_r       <= rd_oob_r ? 8'h00 : mem_char_q;
                rd_colour_r     <= rd_oob_r ? 8'h00 : mem_col_q;
            end else begin
                rd_data_valid_r <= 1'b0;
                rd_char_r       <= rd_char_r;
                rd_colour_r     <= rd_colour_r;
            end
        end
    end

endmodule

// File: tb/tb_text_mem_scheduler.sv
// Bench for text_mem_scheduler: a bench-side RAM pair, a behavioural model of
// page contents and port rules, directed scenarios and a randomized phase.
module tb_text_mem_scheduler;

    localparam int CELLS  = 4800;
    localparam int ADDR_W = 13;

    logic              CLOCK_50 = 1'b0;
    logic              RESET_N;
    logic              disp;
    logic              clr_req;
    logic [7:0]        clr_char;
    logic [7:0]        clr_colour;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_char;
    logic [7:0]        wr_colour;
    logic [1:0]        wr_mask;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_data_valid;
    logic [7:0]        rd_char;
    logic [7:0]        rd_colour;
    logic              mem_own;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_char_d;
    logic [7:0]        mem_col_d;
    logic              mem_char_we;
    logic              mem_col_we;
    logic [7:0]        mem_char_q;
    logic [7:0]        mem_col_q;
    logic              busy;
    logic              clr_done;

    text_mem_scheduler #(.CELLS(CELLS), .ADDR_W(ADDR_W)) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .disp(disp),
        .clr_req(clr_req), .clr_char(clr_char), .clr_colour(clr_colour),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_char(wr_char), .wr_colour(wr_colour), .wr_mask(wr_mask),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_data_valid(rd_data_valid), .rd_char(rd_char), .rd_colour(rd_colour),
        .mem_own(mem_own), .mem_addr(mem_addr), .mem_char_d(mem_char_d),
        .mem_col_d(mem_col_d), .mem_char_we(mem_char_we), .mem_col_we(mem_col_we),
        .mem_char_q(mem_char_q), .mem_col_q(mem_col_q),
        .busy(busy), .clr_done(clr_done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Synchronous RAM pair; scanout drives a random address while it owns them.
    bit [7:0]          ram_c [8192];
    bit [7:0]          ram_k [8192];
    logic [ADDR_W-1:0] scan_addr = '0;
    always @(posedge CLOCK_50) begin
        if (mem_char_we) ram_c[mem_addr] <= mem_char_d;
        if (mem_col_we)  ram_k[mem_addr] <= mem_col_d;
        mem_char_q <= ram_c[mem_own ? mem_addr : scan_addr];
        mem_col_q  <= ram_k[mem_own ? mem_addr : scan_addr];
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model state: page contents, clear progress, read returns.
    bit [7:0] gm_c [CELLS];
    bit [7:0] gm_k [CELLS];
    bit       m_clearing = 1'b0;
    int       m_next     = 0;
    bit [7:0] m_fc = 8'h00, m_fk = 8'h00;
    bit       m_done_due = 1'b0;
    int       q_due [$];
    bit [7:0] q_c [$];
    bit [7:0] q_k [$];
    bit       m_rv = 1'b0;
    bit [7:0] m_rc = 8'h00, m_rk = 8'h00;
    int       cyc = 0;
    int       we_cnt = 0, done_cnt = 0;
    bit       e_wr_rdy, e_rd_rdy, wr_acc, rd_acc, e_cwe, e_kwe, chk_addr, chk_data, new_done;
    int       e_addr;
    bit [7:0] e_cd, e_kd;

    // Compare DUT outputs with the model once per cycle, then advance the model.
    always @(negedge CLOCK_50) begin
        if (!RESET_N) begin
            m_clearing = 1'b0; m_done_due = 1'b0;
            q_due.delete(); q_c.delete(); q_k.delete();
            m_rc = 8'h00; m_rk = 8'h00;
            chk("rst_status", {busy, clr_done, rd_data_valid, mem_char_we, mem_col_we}, 5'b00000);
            chk("rst_rd_data", {rd_char, rd_colour}, 16'h0000);
            chk("rst_mem_addr", mem_addr, 13'h0000);
        end else begin
            m_rv = 1'b0;
            if (q_due.size() > 0 && q_due[0] == cyc) begin
                m_rv = 1'b1;
                m_rc = q_c.pop_front();
                m_rk = q_k.pop_front();
                void'(q_due.pop_front());
            end
            e_wr_rdy = 1'b0; e_rd_rdy = 1'b0; wr_acc = 1'b0; rd_acc = 1'b0;
            e_cwe = 1'b0; e_kwe = 1'b0; e_addr = 0; e_cd = 8'h00; e_kd = 8'h00;
            chk_addr = 1'b1; chk_data = 1'b1;
            if (disp) begin
                chk_addr = 1'b0; chk_data = 1'b0;
            end else if (m_clearing) begin
                e_addr = m_next; e_cd = m_fc; e_kd = m_fk; e_cwe = 1'b1; e_kwe = 1'b1;
            end else begin
                e_wr_rdy = !clr_req;
                e_rd_rdy = !clr_req && !wr_valid;
                wr_acc   = e_wr_rdy && wr_valid;
                rd_acc   = e_rd_rdy && rd_valid;
                if (wr_acc) begin
                    e_addr = wr_addr; e_cd = wr_char; e_kd = wr_colour;
                    if (wr_addr < CELLS) begin e_cwe = wr_mask[0]; e_kwe = wr_mask[1]; end
                end else if (rd_acc) begin
                    e_addr = rd_addr; chk_data = 1'b0;
                end
            end
            chk("handshake", {mem_own, wr_ready, rd_ready}, {!disp, e_wr_rdy, e_rd_rdy});
            chk("write_en", {mem_char_we, mem_col_we}, {e_cwe, e_kwe});
            chk("status", {busy, clr_done}, {m_clearing, m_done_due});
            chk("rd_valid_out", rd_data_valid, m_rv);
            chk("rd_data_out", {rd_char, rd_colour}, {m_rc, m_rk});
            if (chk_addr) chk("mem_addr", mem_addr, e_addr[12:0]);
            if (chk_data) chk("mem_data", {mem_char_d, mem_col_d}, {e_cd, e_kd});
            if (mem_char_we) we_cnt++;
            if (clr_done) done_cnt++;
            new_done = 1'b0;
            if (!m_clearing && clr_req) begin
                m_clearing = 1'b1; m_next = 0; m_fc = clr_char; m_fk = clr_colour;
            end else if (m_clearing && !disp) begin
                gm_c[m_next] = m_fc; gm_k[m_next] = m_fk;
                if (m_next == CELLS - 1) begin m_clearing = 1'b0; new_done = 1'b1; end
                m_next++;
            end
            if (wr_acc && wr_addr < CELLS) begin
                if (wr_mask[0]) gm_c[wr_addr] = wr_char;
                if (wr_mask[1]) gm_k[wr_addr] = wr_colour;
            end
            if (rd_acc) begin
                q_due.push_back(cyc + 2);
                q_c.push_back(rd_addr < CELLS ? gm_c[rd_addr] : 8'h00);
                q_k.push_back(rd_addr < CELLS ? gm_k[rd_addr] : 8'h00);
            end
            m_done_due = new_done;
        end
        cyc++;
    end

    // Advance to one time unit after the next rising edge.
    task automatic cycle();
        @(posedge CLOCK_50);
        #1;
        scan_addr = 13'($urandom_range(0, 8191));
    endtask

    int we0, d0, k;

    initial begin
        RESET_N = 1'b0; disp = 1'b0; clr_req = 1'b0; clr_char = 8'h00; clr_colour = 8'h00;
        wr_valid = 1'b0; wr_addr = '0; wr_char = 8'h00; wr_colour = 8'h00; wr_mask = 2'b00;
        rd_valid = 1'b0; rd_addr = '0;
        repeat (3) cycle();
        RESET_N = 1'b1;
        cycle();

        // Single write, enables in the accept cycle.
        wr_valid = 1'b1; wr_addr = 13'd1234; wr_char = 8'h41; wr_colour = 8'h1F; wr_mask = 2'b01;
        #1;
        chk("t1_wr_ready", wr_ready, 1'b1);
        chk("t1_addr", mem_addr, 13'h04D2);
        chk("t1_we", {mem_char_we, mem_col_we}, 2'b10);
        chk("t1_char_d", mem_char_d, 8'h41);
        cycle();
        wr_valid = 1'b0;

        // Write held off by display, taken on the first blanking cycle.
        disp = 1'b1; wr_valid = 1'b1; wr_addr = 13'd500; wr_char = 8'h55; wr_colour = 8'hAA; wr_mask = 2'b11;
        repeat (15) begin
            #1;
            chk("t2_blocked", {wr_ready, mem_char_we, mem_col_we}, 3'b000);
            cycle();
        end
        disp = 1'b0;
        #1;
        chk("t2_accept", {wr_ready, mem_char_we, mem_col_we}, 3'b111);
        cycle();
        wr_valid = 1'b0;

        // Write then read the same cell on the next cycle.
        wr_valid = 1'b1; wr_addr = 13'd79; wr_char = 8'h41; wr_colour = 8'h3C; wr_mask = 2'b11;
        cycle();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 13'd79;
        #1; chk("t3_rd_ready", rd_ready, 1'b1);
        cycle();
        rd_valid = 1'b0;
        #1; chk("t3_not_yet", rd_data_valid, 1'b0);
        cycle();
        #1; chk("t3_valid", {rd_data_valid, rd_char, rd_colour}, 17'h1413C);
        cycle();
        #1; chk("t3_held", {rd_data_valid, rd_char}, 9'h041);

        // Write beats read; out-of-range write dropped.
        wr_valid = 1'b1; wr_addr = 13'd4800; wr_char = 8'hFF; wr_colour = 8'hFF; wr_mask = 2'b11;
        rd_valid = 1'b1; rd_addr = 13'd1234;
        #1; chk("t4_prio", {wr_ready, rd_ready, mem_char_we, mem_col_we}, 4'b1000);
        cycle();
        wr_valid = 1'b0;
        #1; chk("t4_rd_next", {rd_ready, mem_addr}, {1'b1, 13'd1234});
        cycle();
        rd_valid = 1'b0;
        cycle();
        #1; chk("t4_rd_data", {rd_data_valid, rd_char}, 9'h141);
        cycle();

        // Whole-screen clear with display toggling 10 low / 20 high.
        we0 = we_cnt; d0 = done_cnt;
        clr_req = 1'b1; clr_char = 8'h20; clr_colour = 8'h07;
        cycle();
        clr_req = 1'b0; clr_char = 8'h00; clr_colour = 8'h00;
        #1; chk("t5_busy", busy, 1'b1);
        for (int i = 0; i < 20000 && done_cnt == d0; i++) begin
            disp = ((i % 30) >= 10);
            cycle();
        end
        disp = 1'b0;
        #1;
        chk("t5_we_cycles", we_cnt - we0, 4800);
        chk("t5_done_pulses", done_cnt - d0, 1);
        chk("t5_busy_after", busy, 1'b0);
        chk("t5_model_last", {gm_c[4799], gm_k[4799]}, 16'h2007);
        cycle();

        // Reset in the middle of a clear, then restart from address 0.
        d0 = done_cnt;
        clr_req = 1'b1; clr_char = 8'h2E; clr_colour = 8'h1E;
        cycle();
        clr_req = 1'b0;
        k = 0;
        while (k < 200) begin
            #1;
            if (mem_char_we && mem_addr == 13'd100) break;
            cycle();
            k++;
        end
        chk("t6_reached_100", (k < 200), 1'b1);
        RESET_N = 1'b0;
        #1;
        chk("t6_rst_now", {busy, clr_done, mem_char_we, mem_col_we, mem_addr}, 17'h0);
        cycle(); cycle();
        RESET_N = 1'b1;
        cycle(); cycle();
        chk("t6_no_done", done_cnt - d0, 0);
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        #1; chk("t6_restart", {mem_char_we, mem_addr}, {1'b1, 13'd0});
        for (int i = 0; i < 6000 && busy; i++) cycle();
        chk("t6_finished", busy, 1'b0);
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            disp       = ($urandom_range(0, 3) == 0);
            wr_valid   = ($urandom_range(0, 2) == 0);
            wr_addr    = 13'($urandom_range(0, 4815));
            wr_char    = 8'($urandom);
            wr_colour  = 8'($urandom);
            wr_mask    = 2'($urandom_range(0, 3));
            rd_valid   = ($urandom_range(0, 1) == 0);
            rd_addr    = ($urandom_range(0, 7) == 0) ? 13'($urandom_range(4790, 8191))
                                                     : 13'($urandom_range(0, 4799));
            clr_req    = ($urandom_range(0, 1499) == 0);
            clr_char   = 8'($urandom);
            clr_colour = 8'($urandom);
            cycle();
        end
        disp = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; clr_req = 1'b0;
        repeat (4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case a scenario stalls.
    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
